// File: rtl/serial_neg_scheduler.sv
// -----------------------------------------------------------------------------
// serial_neg_scheduler
//
// Arbitrates between two requesters that want a WIDTH-bit word negated. The
// operation runs on an external bit-serial negator. The served operand is
// streamed out LSB first on neg_in. neg_out is collected into a result shift
// register, and the finished word is presented on dout with a one-cycle done.
//
// Sequence per operation:
//   IDLE  -> grant one requester, pulse its ack, capture din and id
//   CLR   -> one cycle of neg_reset so the negator forgets the last operand
//   SHIFT -> WIDTH cycles, one operand bit out and one result bit in per cycle
//   DONE  -> done pulse, dout/dout_id already valid
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   reset      in   asynchronous, active-high reset
//   req0/req1  in   requester 0/1 wants a word negated (held until acked)
//   din0/din1  in   operand of requester 0/1 (stable while its req is high)
//   ack0/ack1  out  operand of requester 0/1 is captured at this cycle's edge
//   busy       out  any state other than IDLE
//   done       out  one-cycle pulse; dout/dout_id are valid
//   dout       out  two's complement negation of the served operand
//   dout_id    out  requester index that dout belongs to
//   neg_in     out  serial operand bit to the negator, LSB first
//   neg_reset  out  clears the negator's "seen a 1" state
//   neg_out    in   negator serial output (combinational from neg_in)
// -----------------------------------------------------------------------------
module serial_neg_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             dout_id,
  output logic             neg_in,
  output logic             neg_reset,
  input  logic             neg_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op;       // operand, shifted right one bit per SHIFT cycle
  logic [WIDTH-1:0] r_res;      // result, neg_out enters at the MSB
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_id;
  logic             r_id;       // requester of the operation in flight
  logic             r_last;     // requester served most recently
  logic [CW-1:0]    r_cnt;

  logic             w_any_req;
  logic             w_grant_id;
  logic             w_grant;
  logic [WIDTH-1:0] w_res_next;

  // NOTE: every signal driven in always_comb gets a value on every path.
  // Otherwise the tool infers a latch.
  always_comb begin
    w_any_req  = req0 | req1;
    // Round-robin: if both are asking, serve the one that did not go last.
    // If only one is asking, req1 alone selects its own index.
    w_grant_id = (req0 && req1) ? ~r_last : req1;
    // reset gates the grant. Requests held through reset are not acked
    // until reset is released.
    w_grant    = (r_state == S_IDLE) && w_any_req && !reset;
    w_res_next = {neg_out, r_res[WIDTH-1:1]};
  end

  // ack is combinational on purpose. It must appear in the same IDLE cycle
  // whose closing edge captures the operand.
  assign ack0      = w_grant && !w_grant_id;
  assign ack1      = w_grant &&  w_grant_id;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dout      = r_dout;
  assign dout_id   = r_dout_id;
  assign neg_in    = (r_state == S_SHIFT) && r_op[0];
  assign neg_reset = reset || (r_state == S_CLR);

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, whatever order the statements are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_res     <= '0;
      r_dout    <= '0;
      r_dout_id <= 1'b0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_op    <= w_grant_id ? din1 : din0;
            r_id    <= w_grant_id;
            r_last  <= w_grant_id;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_cnt   <= '0;
          r_res   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_op  <= r_op >> 1;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          // The last bit goes straight into dout, so dout is valid while
          // done is high.
          if (r_cnt == LAST_BIT) begin
            r_dout    <= w_res_next;
            r_dout_id <= r_id;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_neg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_neg_scheduler
//
// Bench for serial_neg_scheduler (WIDTH=8) with a behavioural bit-serial
// negator attached. Stimulus pushes the expected {id, result} for each
// operation into a queue. A monitor pops it on every done pulse and checks
// dout, dout_id and the ack-to-done latency.
// -----------------------------------------------------------------------------
module tb_serial_neg_scheduler;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] din0 = '0;
  logic [WIDTH-1:0] din1 = '0;
  logic             ack0, ack1, busy, done, dout_id, neg_in, neg_reset, neg_out;
  logic [WIDTH-1:0] dout;

  serial_neg_scheduler #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .din0      (din0),
    .din1      (din1),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .dout_id   (dout_id),
    .neg_in    (neg_in),
    .neg_reset (neg_reset),
    .neg_out   (neg_out)
  );

  always #5 clk = ~clk;

  // Bit-serial negator: pass bits through until the first 1, then invert.
  logic seen;
  always @(posedge clk) begin
    if (neg_reset) seen <= 1'b0;
    else if (neg_in) seen <= 1'b1;
  end
  assign neg_out = neg_in ^ seen;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               id;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_ack_cyc  = -1;
  int   last_done_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ack0 && ack1) check("dual_ack", 1, 0);
        if (ack0 || ack1) last_ack_cyc = cyc;
        if (done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("dout", dout, e.val);
            check("dout_id", dout_id, e.id);
            check("latency", cyc - last_ack_cyc, WIDTH + 2);
          end
          last_done_cyc = cyc;
        end
      end
    end
  end

  // Raise one request, wait for its ack, then drop it. Returns at
  // posedge+1 of the CLR cycle.
  task automatic do_req(input bit id, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] exp, input bit push);
    bit got = 1'b0;
    if (push) sb_q.push_back('{id, exp});
    @(posedge clk); #1;
    if (id) begin din1 = d; req1 = 1'b1; end
    else    begin din0 = d; req0 = 1'b1; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) got = 1'b1;
    end
    if (!got) check("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb_q.size() > 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  // Boundary operands and hand-computed negations.
  logic [WIDTH-1:0] vec_in  [5] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h1C};
  logic [WIDTH-1:0] vec_exp [5] = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'hE4};
  // neg_in per SHIFT cycle for operand 0x7C, cycle 0 first.
  bit               pat_7c  [8] = '{0, 0, 1, 1, 1, 1, 1, 0};

  initial begin
    bit got;
    int n, prev;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_id", dout_id, 0);
    check("rst_neg_in", neg_in, 0);
    check("rst_neg_reset", neg_reset, 1);
    @(posedge clk); #1 reset = 1'b0;

    // Operand 0x7C: check the CLR cycle and the serial bit order.
    do_req(1'b0, 8'h7C, 8'h84, 1'b1);
    @(negedge clk);
    check("clr_neg_reset", neg_reset, 1);
    check("clr_neg_in", neg_in, 0);
    check("clr_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("neg_in_bit%0d", k), neg_in, pat_7c[k]);
      check($sformatf("shift_neg_reset%0d", k), neg_reset, 0);
    end
    wait_drain();

    // Boundary operands, alternating requesters.
    for (int i = 0; i < 5; i++) begin
      do_req(i[0], vec_in[i], vec_exp[i], 1'b1);
      wait_drain();
    end

    // The negator state must not leak from 0x01 into 0x00.
    do_req(1'b0, 8'h01, 8'hFF, 1'b1);
    wait_drain();
    do_req(1'b0, 8'h00, 8'h00, 1'b1);
    wait_drain();

    // req1 raised while busy: acked only in the IDLE cycle after done.
    // din1 changes before the ack, and the later value is used.
    do_req(1'b0, 8'h10, 8'hF0, 1'b1);
    sb_q.push_back('{1'b1, 8'hFD});
    din1 = 8'h33;
    req1 = 1'b1;
    got  = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (i == 4) din1 = 8'h03;
      if (ack1) begin
        got = 1'b1;
        check("ack1_after_done", cyc - last_done_cyc, 1);
      end
    end
    if (!got) check("ack1_timeout", 0, 1);
    @(posedge clk); #1 req1 = 1'b0;
    wait_drain();

    // Reset during SHIFT cycle 3 discards the operation.
    do_req(1'b0, 8'h55, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_neg_reset", neg_reset, 1);
    check("midrst_dout", dout, 0);
    check("midrst_dout_id", dout_id, 0);
    @(posedge clk); #1 reset = 1'b0;
    do_req(1'b1, 8'h02, 8'hFE, 1'b1);
    wait_drain();

    // Both requesters held from reset: served 0,1,0,1 with acks 11 cycles apart.
    @(posedge clk); #1;
    reset = 1'b1;
    din0  = 8'h05;
    din1  = 8'h10;
    req0  = 1'b1;
    req1  = 1'b1;
    sb_q.push_back('{1'b0, 8'hFB});
    sb_q.push_back('{1'b1, 8'hF0});
    sb_q.push_back('{1'b0, 8'hFB});
    sb_q.push_back('{1'b1, 8'hF0});
    #1;
    check("rst_held_ack0", ack0, 0);
    @(posedge clk); #1 reset = 1'b0;
    n    = 0;
    prev = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check($sformatf("rr_order%0d", n), ack1, n % 2);
        if (n > 0) check($sformatf("ack_spacing%0d", n), cyc - prev, WIDTH + 3);
        prev = cyc;
        n++;
      end
    end
    check("rr_ack_count", n, 4);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
